// File: rtl/trap_pkg.sv
// trap_pkg: shared trap FSM states, request kinds and the timer-interrupt cause.
// Used by the trap controller, the CSR file and the hazard unit.
package trap_pkg;
  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_COMMIT, S_REDIRECT} state_t;
  typedef enum logic [1:0] {K_NONE, K_EXC, K_INT, K_MRET} kind_t;
  localparam logic [31:0] CAUSE_TIMER_INT = 32'h8000_0007;
endpackage

// File: rtl/trap_controller_target.sv
// trap_target_calc: combinational redirect target for a trap or an MRET.
// Ports: i_kind (latched request kind), i_cause (latched cause),
//        i_mtvec / i_mepc (current CSR values), o_pc (redirect target).
module trap_target_calc
  import trap_pkg::*;
(
  input  kind_t       i_kind,
  input  logic [31:0] i_cause,
  input  logic [31:0] i_mtvec,
  input  logic [31:0] i_mepc,
  output logic [31:0] o_pc
);
  logic [31:0] w_base;
  logic        w_vectored;
  logic        w_unused;
  assign w_base     = {i_mtvec[31:2], 2'b00};
  // Vectored mode only applies to interrupts (cause MSB set).
  assign w_vectored = (i_mtvec[1:0] == 2'b01) && i_cause[31];
  assign o_pc       = (i_kind == K_MRET) ? {i_mepc[31:2], 2'b00} :
                      w_vectored ? w_base + 32'({i_cause[30:0], 2'b00}) : w_base;
  assign w_unused   = ^i_mepc[1:0];
endmodule

// File: rtl/trap_controller.sv
// trap_controller: arbitrates interrupt/exception/MRET, drains the pipeline,
// commits CSR updates and redirects fetch.
// Inputs : i_clk, i_rst_n (sync, active-low), i_exception_request/cause/pc,
//          i_interrupt_pending, i_mret_request, i_resume_pc_in,
//          i_pipeline_idle, i_mtvec_in, i_mepc_in, i_redirect_ready.
// Outputs: o_pipeline_stall, o_pipeline_flush, o_trap_ack, o_drain_timeout,
//          o_csr_exception_enable/pc/cause, o_csr_machine_return_enable,
//          o_redirect_valid, o_redirect_pc, o_busy.
module trap_controller
  import trap_pkg::*;
#(
  parameter int unsigned DRAIN_TIMEOUT = 15
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_exception_request,
  input  logic [31:0] i_exception_cause_in,
  input  logic [31:0] i_exception_pc_in,
  input  logic        i_interrupt_pending,
  input  logic        i_mret_request,
  input  logic [31:0] i_resume_pc_in,
  input  logic        i_pipeline_idle,
  input  logic [31:0] i_mtvec_in,
  input  logic [31:0] i_mepc_in,
  input  logic        i_redirect_ready,
  output logic        o_pipeline_stall,
  output logic        o_pipeline_flush,
  output logic        o_trap_ack,
  output logic        o_drain_timeout,
  output logic        o_csr_exception_enable,
  output logic [31:0] o_csr_exception_pc,
  output logic [31:0] o_csr_exception_cause,
  output logic        o_csr_machine_return_enable,
  output logic        o_redirect_valid,
  output logic [31:0] o_redirect_pc,
  output logic        o_busy
);
  state_t      r_state, w_next;
  kind_t       r_kind;
  logic [31:0] r_cause, r_pc;
  logic [7:0]  r_cnt;
  logic        w_trap, w_cnt_hit;
  logic [31:0] w_target;

  assign w_trap    = (r_kind != K_MRET);
  assign w_cnt_hit = (r_cnt == 8'(DRAIN_TIMEOUT));

  trap_target_calc u_target (
    .i_kind  (r_kind),
    .i_cause (r_cause),
    .i_mtvec (i_mtvec_in),
    .i_mepc  (i_mepc_in),
    .o_pc    (w_target)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_kind  <= K_NONE;
      r_cause <= '0;
      r_pc    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (r_state == S_DRAIN) ? r_cnt + 8'd1 : 8'd0;
      if (r_state == S_IDLE) begin
        if (i_interrupt_pending) begin
          r_kind  <= K_INT;
          r_cause <= CAUSE_TIMER_INT;
          r_pc    <= i_resume_pc_in;
        end else if (i_exception_request) begin
          r_kind  <= K_EXC;
          r_cause <= i_exception_cause_in;
          r_pc    <= i_exception_pc_in;
        end else if (i_mret_request) begin
          r_kind  <= K_MRET;
          r_cause <= '0;
          r_pc    <= '0;
        end
      end
    end
  end

  // Outputs are forced low while reset is asserted, so an abandoned trap
  // never shows a CSR enable even in the reset cycle itself.
  always_comb begin
    w_next                      = r_state;
    o_pipeline_stall            = 1'b0;
    o_pipeline_flush            = 1'b0;
    o_trap_ack                  = 1'b0;
    o_drain_timeout             = 1'b0;
    o_csr_exception_enable      = 1'b0;
    o_csr_exception_pc          = '0;
    o_csr_exception_cause       = '0;
    o_csr_machine_return_enable = 1'b0;
    o_redirect_valid            = 1'b0;
    o_redirect_pc               = '0;
    o_busy                      = i_rst_n && (r_state != S_IDLE);
    if (i_rst_n) begin
      case (r_state)
        S_IDLE: w_next = (i_interrupt_pending || i_exception_request || i_mret_request) ? S_DRAIN : S_IDLE;
        S_DRAIN: begin
          o_pipeline_stall = 1'b1;
          o_drain_timeout  = w_cnt_hit && !i_pipeline_idle;
          w_next           = (i_pipeline_idle || w_cnt_hit) ? S_COMMIT : S_DRAIN;
        end
        S_COMMIT: begin
          o_pipeline_stall            = 1'b1;
          o_pipeline_flush            = 1'b1;
          o_trap_ack                  = 1'b1;
          o_csr_exception_enable      = w_trap;
          o_csr_machine_return_enable = !w_trap;
          o_csr_exception_pc          = w_trap ? r_pc : 32'd0;
          o_csr_exception_cause       = w_trap ? r_cause : 32'd0;
          w_next                      = S_REDIRECT;
        end
        default: begin
          o_pipeline_stall = 1'b1;
          o_redirect_valid = 1'b1;
          o_redirect_pc    = w_target;
          w_next           = i_redirect_ready ? S_IDLE : S_REDIRECT;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_trap_controller.sv
// tb_trap_controller: directed self-checking bench for trap_controller.
module tb_trap_controller;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        exc_req = 1'b0, int_pend = 1'b0, mret_req = 1'b0;
  logic        pipe_idle = 1'b0, rdy = 1'b0;
  logic [31:0] exc_cause = '0, exc_pc = '0, resume_pc = '0;
  logic [31:0] mtvec = 32'h200, mepc = '0;
  logic        stall, flush, ack, dto, exc_en, mret_en, rvalid, busy;
  logic [31:0] csr_pc, csr_cause, rpc;
  int          n_checks = 0, n_errors = 0;
  logic        mon = 1'b0, seen_en = 1'b0;
  int          early;

  trap_controller #(.DRAIN_TIMEOUT(15)) dut (
    .i_clk                       (clk),
    .i_rst_n                     (rst_n),
    .i_exception_request         (exc_req),
    .i_exception_cause_in        (exc_cause),
    .i_exception_pc_in           (exc_pc),
    .i_interrupt_pending         (int_pend),
    .i_mret_request              (mret_req),
    .i_resume_pc_in              (resume_pc),
    .i_pipeline_idle             (pipe_idle),
    .i_mtvec_in                  (mtvec),
    .i_mepc_in                   (mepc),
    .i_redirect_ready            (rdy),
    .o_pipeline_stall            (stall),
    .o_pipeline_flush            (flush),
    .o_trap_ack                  (ack),
    .o_drain_timeout             (dto),
    .o_csr_exception_enable      (exc_en),
    .o_csr_exception_pc          (csr_pc),
    .o_csr_exception_cause       (csr_cause),
    .o_csr_machine_return_enable (mret_en),
    .o_redirect_valid            (rvalid),
    .o_redirect_pc               (rpc),
    .o_busy                      (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (mon) seen_en <= seen_en | exc_en | mret_en;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tick();
    tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_stall", 32'(stall), 0);
    check("rst_rvalid", 32'(rvalid), 0);
    check("rst_csr_pc", csr_pc, 0);
    rst_n = 1'b1;
    // exception, pipeline already idle
    exc_req = 1'b1; exc_cause = 32'd2; exc_pc = 32'h100; pipe_idle = 1'b1; rdy = 1'b1;
    tick();
    check("t1_drain_stall", 32'(stall), 1);
    check("t1_drain_flush", 32'(flush), 0);
    tick();
    check("t1_flush", 32'(flush), 1);
    check("t1_ack", 32'(ack), 1);
    check("t1_exc_en", 32'(exc_en), 1);
    check("t1_mret_en", 32'(mret_en), 0);
    check("t1_csr_pc", csr_pc, 32'h100);
    check("t1_csr_cause", csr_cause, 32'd2);
    exc_req = 1'b0;
    tick();
    check("t1_rvalid", 32'(rvalid), 1);
    check("t1_rpc", rpc, 32'h200);
    check("t1_csr_pc_off", csr_pc, 0);
    tick();
    check("t1_idle_busy", 32'(busy), 0);
    check("t1_idle_stall", 32'(stall), 0);
    // interrupt beats exception, vectored mtvec
    mtvec = 32'h201; int_pend = 1'b1; resume_pc = 32'h400;
    exc_req = 1'b1; exc_cause = 32'd2; exc_pc = 32'h300;
    tick();
    tick();
    check("t2_int_cause", csr_cause, 32'h8000_0007);
    check("t2_int_pc", csr_pc, 32'h400);
    int_pend = 1'b0;
    tick();
    check("t2_int_rpc", rpc, 32'h21C);
    tick();
    check("t2_back_idle", 32'(busy), 0);
    tick();
    check("t2_exc_drain", 32'(busy), 1);
    tick();
    check("t2_exc_cause", csr_cause, 32'd2);
    check("t2_exc_pc", csr_pc, 32'h300);
    exc_req = 1'b0;
    tick();
    check("t2_exc_rpc", rpc, 32'h200);
    tick();
    // drain timeout, interrupt dropped mid-drain
    mtvec = 32'h200; pipe_idle = 1'b0; int_pend = 1'b1; resume_pc = 32'h500;
    tick();
    int_pend = 1'b0;
    early = 0;
    for (int i = 0; i < 15; i++) begin
      early += int'(dto);
      tick();
    end
    check("t3_no_early_dto", 32'(early), 0);
    check("t3_dto", 32'(dto), 1);
    check("t3_dto_stall", 32'(stall), 1);
    check("t3_dto_flush", 32'(flush), 0);
    tick();
    check("t3_commit_en", 32'(exc_en), 1);
    check("t3_commit_cause", csr_cause, 32'h8000_0007);
    check("t3_dto_off", 32'(dto), 0);
    pipe_idle = 1'b1;
    tick();
    tick();
    // mret
    mret_req = 1'b1; mepc = 32'h1003;
    tick();
    tick();
    check("t4_mret_en", 32'(mret_en), 1);
    check("t4_exc_en", 32'(exc_en), 0);
    check("t4_ack", 32'(ack), 1);
    mret_req = 1'b0;
    tick();
    check("t4_mret_en_off", 32'(mret_en), 0);
    check("t4_rpc", rpc, 32'h1000);
    tick();
    // redirect back-pressure, request during REDIRECT
    rdy = 1'b0; exc_req = 1'b1; exc_cause = 32'd5; exc_pc = 32'h600;
    tick();
    tick();
    exc_req = 1'b0;
    tick();
    exc_req = 1'b1; exc_cause = 32'd3; exc_pc = 32'h700;
    for (int i = 0; i < 3; i++) begin
      check("t5_rvalid", 32'(rvalid), 1);
      check("t5_rpc", rpc, 32'h200);
      check("t5_no_ack", 32'(ack), 0);
      tick();
    end
    rdy = 1'b1;
    tick();
    check("t5_idle", 32'(busy), 0);
    check("t5_idle_ack", 32'(ack), 0);
    tick();
    check("t5_drain_ack", 32'(ack), 0);
    tick();
    check("t5_ack", 32'(ack), 1);
    check("t5_cause", csr_cause, 32'd3);
    exc_req = 1'b0;
    tick();
    tick();
    // reset in DRAIN
    pipe_idle = 1'b0; exc_req = 1'b1; exc_cause = 32'd4; mon = 1'b1;
    tick();
    check("t6_busy_drain", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("t6_stall_in_rst", 32'(stall), 0);
    tick();
    check("t6_busy", 32'(busy), 0);
    check("t6_stall", 32'(stall), 0);
    exc_req = 1'b0; rst_n = 1'b1;
    tick();
    tick();
    tick();
    check("t6_busy_after", 32'(busy), 0);
    check("t6_no_csr_en", 32'(seen_en), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/trap_controller.md
TRAP_CONTROLLER -- requirements
Module: trap_controller

Interface
REQ-001 SHALL have parameter DRAIN_TIMEOUT, default 15, max cycles spent waiting for pipeline drain (range 1..255).
REQ-002 SHALL have ports: clk  in  1  clock; one clock domain, all logic on rising edge.
REQ-003 rst_n  in  1  reset; synchronous, active-low.
REQ-004 exception_request  in  1  level; pipeline holds it until trap_ack.
REQ-005 exception_cause_in  in  32  cause code for exception_request.
REQ-006 exception_pc_in  in  32  PC of the faulting instruction.
REQ-007 interrupt_pending  in  1  level; CSR-file timer interrupt fire, already gated by MIE/MTIE.
REQ-008 mret_request  in  1  level; MRET reached commit point.
REQ-009 resume_pc_in  in  32  PC of the oldest uncommitted instruction, saved as mepc on interrupt.
REQ-010 pipeline_idle  in  1  no instruction older than the trap point is in flight.
REQ-011 mtvec_in / mepc_in  in  32 each  current CSR values.
REQ-012 redirect_ready  in  1  fetch accepts the redirect.
REQ-013 pipeline_stall  out  1; pipeline_flush  out  1; trap_ack  out  1; drain_timeout  out  1.
REQ-014 csr_exception_enable  out  1; csr_exception_pc  out  32; csr_exception_cause  out  32; csr_machine_return_enable  out  1.
REQ-015 redirect_valid  out  1; redirect_pc  out  32; busy  out  1 (state != IDLE).

Function
REQ-016 SHALL implement FSM IDLE, DRAIN, COMMIT, REDIRECT.
REQ-017 In IDLE, priority SHALL be interrupt_pending > exception_request > mret_request. The winner's kind, cause and PC are latched and the FSM moves to DRAIN next cycle.
REQ-018 Latched values: interrupt uses cause 0x80000007 and resume_pc_in; exception uses exception_cause_in and exception_pc_in; mret latches only its kind.
REQ-019 Requests arriving outside IDLE SHALL be ignored. The latched request SHALL complete even if its input deasserts during DRAIN.
REQ-020 pipeline_stall SHALL be 1 in DRAIN, COMMIT and REDIRECT, and 0 in IDLE.
REQ-021 DRAIN SHALL run an 8-bit counter from 0. The FSM leaves for COMMIT when pipeline_idle=1 or the counter equals DRAIN_TIMEOUT, whichever comes first.
REQ-022 On a timeout exit, drain_timeout SHALL pulse for one cycle. If pipeline_idle=1 in the first DRAIN cycle, DRAIN SHALL last exactly one cycle.
REQ-023 COMMIT SHALL last exactly one cycle and assert, in that cycle, pipeline_flush=1 and trap_ack=1.
REQ-024 In COMMIT, a trap kind SHALL also assert csr_exception_enable=1 with the latched pc and cause; the mret kind SHALL instead assert csr_machine_return_enable=1. Both enables SHALL never be 1 in the same cycle.
REQ-025 REDIRECT SHALL hold redirect_valid=1 with a stable redirect_pc until redirect_ready=1, then return to IDLE the next cycle. A new request SHALL be capturable in the first IDLE cycle.
REQ-026 redirect_pc SHALL be computed from mtvec_in and mepc_in in REDIRECT, i.e. after the CSR update.
REQ-027 Trap redirect_pc SHALL be base = {mtvec_in[31:2],2'b00}, except that when mtvec_in[1:0]==01 and cause[31]=1 it is base + (cause[30:0] << 2), truncated to 32 bits.
REQ-028 mret redirect_pc SHALL be {mepc_in[31:2],2'b00}.

Reset
REQ-029 With rst_n=0 at a clock edge, the FSM SHALL go to IDLE and the counter and all latches SHALL clear to 0.
REQ-030 All outputs SHALL be 0 in reset and IDLE, except csr_exception_pc and csr_exception_cause, which SHALL be 0 whenever not in COMMIT.
REQ-031 Reset mid-operation SHALL abandon the trap without issuing any CSR enable.

Structure
REQ-032 State encodings, cause constant 0x80000007 and the kind encodings SHALL live in the shared CPU package/include, for reuse by the CSR file and hazard unit.
REQ-033 Target computation SHALL be a combinational sub-module, trap_target_calc (inputs: kind, cause, mtvec, mepc; output: pc).

Verification
REQ-034 Exception with cause=2, pc=0x100, mtvec=0x200, pipeline_idle=1 -> DRAIN 1 cycle; COMMIT with csr_exception_enable=1, pc=0x100, cause=2, flush=1; redirect_pc=0x200.
REQ-035 interrupt_pending and exception_request in the same cycle, mtvec=0x201 -> interrupt wins, cause 0x80000007, redirect_pc=0x21C; the exception is taken after return to IDLE.
REQ-036 pipeline_idle held 0 -> drain_timeout pulses after 15 DRAIN cycles and COMMIT follows; interrupt dropped mid-DRAIN -> trap is still committed.
REQ-037 mret with mepc=0x1003 -> csr_machine_return_enable=1 for 1 cycle, redirect_pc=0x1000.
REQ-038 redirect_ready low for 3 cycles -> redirect_valid and redirect_pc stable; a new exception_request during that time is not acked until after IDLE.
REQ-039 rst_n=0 during DRAIN -> next cycle IDLE, stall=0, no CSR enable ever asserted.
